io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//  Shares one 8-bit I/O port bus (a1_a0, d7_d0, ior_, iow_) among N_REQ requesters.
//  A round-robin arbiter picks one pending request and runs a single read or write bus cycle.
//  Strobe widths are parameterised. Read data and a per-requester done pulse are returned.
//  Sits between the engine FSMs and the external I/O interface; it is the only bus driver.
// PARAMETERS
//  N_REQ    4  number of requesters, 2..8
//  RD_WAIT  2  clocks ior_ is held low, 1..15
//  WR_WAIT  2  clocks iow_ is held low, 1..15
// PORTS
//  clock      in     1        system clock, all logic on posedge
//  reset      in     1        synchronous reset, active-high
//  req        in     N_REQ    per-requester request level, held until its done pulse
//  req_wr     in     N_REQ    1=write, 0=read; sampled at grant
//  req_addr   in     2*N_REQ  port address, requester k uses bits [2k+1:2k]
//  req_wdata  in     8*N_REQ  write data, requester k uses bits [8k+7:8k]
//  done       out    N_REQ    one-clock completion pulse, one-hot
//  rdata      out    8        read data; valid while done is high and held until the next read
//  busy       out    1        high in every state except IDLE
//  a1_a0      out    2        I/O port address
//  d7_d0      inout  8        I/O data bus; driven only while dir=1, otherwise 'hZZ
//  ior_       out    1        read strobe, active-low
//  iow_       out    1        write strobe, active-low
// BEHAVIOUR
//  - All outputs are registered. The bus driver enable (dir) is an internal register.
//  - Reset is applied at any posedge with reset=1, including mid-transaction:
//    - state<=IDLE, ior_<=1, iow_<=1, dir<=0, a1_a0<=0, rdata<=0, done<=0, busy<=0.
//    - Round-robin pointer last<=N_REQ-1, so requester 0 has first priority.
//    - Any in-flight transaction is abandoned; no done pulse is produced for it.
//  - FSM states: IDLE, SETUP, RD, WR_DATA, WR, HOLD. A 4-bit counter cnt times the strobes.
//  - IDLE: if req!=0, winner w = first set bit scanning last+1, last+2, ... modulo N_REQ.
//    - Latch w, req_wr[w], req_addr[w], req_wdata[w]; a1_a0<=addr; last<=w; go to SETUP.
//    - Changes to a requester's inputs after its grant are ignored.
//  - SETUP (1 clock, address setup):
//    - Read: ior_<=0, cnt<=RD_WAIT-1, go to RD.
//    - Write: dir<=1, go to WR_DATA.
//  - RD: if cnt==0 then rdata<=d7_d0, ior_<=1, done[w]<=1, go to HOLD; else cnt<=cnt-1.
//  - WR_DATA (1 clock, data setup): iow_<=0, cnt<=WR_WAIT-1, go to WR.
//  - WR: if cnt==0 then iow_<=1, done[w]<=1, go to HOLD; else cnt<=cnt-1.
//    - Data stays driven through HOLD for hold time.
//  - HOLD: done<=0, dir<=0, go to IDLE. a1_a0 keeps its value until the next grant.
//  - Timing, with E0 = the grant edge:
//    - Read: ior_ low E1..E(1+RD_WAIT); done high from E(1+RD_WAIT) to E(2+RD_WAIT).
//    - Write: dir high E1..E(3+WR_WAIT); iow_ low E2..E(2+WR_WAIT); done high E(2+WR_WAIT)..E(3+WR_WAIT).
//  - The next grant happens no earlier than one IDLE clock after HOLD.
//    - Back-to-back read period is RD_WAIT+3 clocks.
//  - Handshake:
//    - A requester drops req on the clock it sees done.
//    - If req is still high when IDLE evaluates, it is a new request.
//    - Dropping req before grant withdraws it. Dropping req after grant does not cancel the bus cycle.
//  - Invariants:
//    - ior_ and iow_ are never low together.
//    - dir=1 never overlaps ior_=0.
//    - At most one done bit is set.
// TESTING
//  1. Single read: req=4'b0001, req_wr=0, addr=2, bus returns 8'hA5, RD_WAIT=2
//     -> a1_a0=2; ior_ low exactly 2 clocks; done=0001 for 1 clock; rdata=8'hA5.
//  2. Single write: req[2], wdata=8'h3C, addr=1
//     -> d7_d0=8'h3C from E1 to E5; iow_ low exactly WR_WAIT clocks inside that window; done=0100.
//  3. All four requesters request continuously after reset
//     -> grant order 0,1,2,3,0; no requester served twice before the others.
//  4. Requester 1 alone, re-requests immediately after done, while requester 3 becomes pending
//     -> requester 3 is granted before requester 1's second transaction.
//  5. reset=1 while ior_ or iow_ is low mid-strobe
//     -> next edge: strobes=1, d7_d0 Hi-Z, busy=0, no done pulse; requester 0 wins the next arbitration.
//  6. Checker over randomised req traffic
//     -> invariants hold; ior_ never low while dir=1; done is one-hot per cycle.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter that shares one 8-bit I/O port bus among N_REQ requesters.
// Each grant runs one read or write strobe cycle; strobe widths come from RD_WAIT/WR_WAIT.
module io_bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_wr,
    input  logic [2*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         rdata,
    output logic               busy,
    output logic [1:0]         a1_a0,
    inout  wire  [7:0]         d7_d0,
    output logic               ior_,
    output logic               iow_
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, RD, WR_DATA, WR, HOLD} state_t;

    state_t        state, state_n;
    logic [IW-1:0] last, win, sel;
    logic          found;
    logic          wr_q;
    logic          dir;
    logic [7:0]    wdata_q;
    logic [3:0]    cnt;
    int            rr_idx;

    assign d7_d0 = dir ? wdata_q : 8'hzz;

    // First pending request after the previous winner, wrapping modulo N_REQ.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_idx = int'(last) + i;
            if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
            if (!found && req[rr_idx]) begin
                found = 1'b1;
                win   = IW'(rr_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = SETUP;
            SETUP:   state_n = wr_q ? WR_DATA : RD;
            RD:      if (cnt == 4'd0) state_n = HOLD;
            WR_DATA: state_n = WR;
            WR:      if (cnt == 4'd0) state_n = HOLD;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus-facing outputs are all registered; busy tracks the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            ior_    <= 1'b1;
            iow_    <= 1'b1;
            dir     <= 1'b0;
            a1_a0   <= 2'd0;
            rdata   <= 8'd0;
            done    <= '0;
            busy    <= 1'b0;
            last    <= IW'(N_REQ - 1);
            sel     <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 8'd0;
            cnt     <= 4'd0;
        end else begin
            busy <= (state_n != IDLE);
            case (state)
                IDLE: if (found) begin
                    sel     <= win;
                    last    <= win;
                    wr_q    <= req_wr[win];
                    a1_a0   <= req_addr[{win, 1'b0} +: 2];
                    wdata_q <= req_wdata[{win, 3'b000} +: 8];
                end
                SETUP: begin
                    if (wr_q) begin
                        dir <= 1'b1;
                    end else begin
                        ior_ <= 1'b0;
                        cnt  <= 4'(RD_WAIT - 1);
                    end
                end
                RD: begin
                    if (cnt == 4'd0) begin
                        rdata     <= d7_d0;
                        ior_      <= 1'b1;
                        done[sel] <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_DATA: begin
                    iow_ <= 1'b0;
                    cnt  <= 4'(WR_WAIT - 1);
                end
                WR: begin
                    if (cnt == 4'd0) begin
                        iow_      <= 1'b1;
                        done[sel] <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    done <= '0;
                    dir  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
